// File: rtl/seq_det_pkg.sv
// Shared types and default parameter values for the sequence-detector event logger.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } log_state_t;

  localparam int unsigned TS_W_DEF   = 16;
  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned MAX_EV_DEF = 0;

endpackage

// File: rtl/seq_det_ts_fifo.sv
// Synchronous FIFO for event stamps. A write to a full FIFO is accepted only
// when a pop happens in the same cycle. There is no write-to-read bypass.
module seq_det_ts_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Wr_En,
  input  logic [W-1:0] Wr_Data,
  input  logic         Rd_En,
  output logic [W-1:0] Rd_Data,
  output logic         Full,
  output logic         Empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_wr, do_rd;

  assign Full    = (count_q == CW'(DEPTH));
  assign Empty   = (count_q == '0);
  assign Rd_Data = Empty ? '0 : mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_rd    = Rd_En && !Empty;
    do_wr    = Wr_En && (!Full || do_rd);
    if (do_wr) begin
      mem_d[wr_ptr_q] = Wr_Data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards all queued entries.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/seq_det_event_logger.sv
// Event logger for the sequence-detector output: counts Det cycles while armed,
// stamps each with a free-running timestamp and queues the stamp in a FIFO
// drained through a ready/valid port.
// Optional feature: define SEQ_LOG_GAP_EN to store the cycles elapsed since the
// previous event (or since Start) instead of the absolute timestamp.
module seq_det_event_logger
  import seq_det_pkg::*;
#(
  parameter int unsigned TS_W   = TS_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned MAX_EV = MAX_EV_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Det,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Rd_Ready,
  output logic             Rd_Valid,
  output logic [TS_W-1:0]  Rd_Data,
  output logic [CNT_W-1:0] Ev_Count,
  output logic             Ovf,
  output logic             Busy
);

  log_state_t       state_q, state_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] ev_count_q, ev_count_d;
  logic             ovf_q, ovf_d;
  logic             arm;
  logic             log_ev;
  logic             pop;
  logic [TS_W-1:0]  wr_data;
  logic             fifo_full, fifo_empty;
`ifdef SEQ_LOG_GAP_EN
  logic [TS_W-1:0]  gap_q, gap_d;
`endif

  assign Rd_Valid = !fifo_empty;
  assign Busy     = (state_q == ARMED);
  assign Ev_Count = ev_count_q;
  assign Ovf      = ovf_q;

  // Capture FSM, event counter, overflow flag and timestamp next-state.
  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q + TS_W'(1);
    ev_count_d = ev_count_q;
    ovf_d      = ovf_q;
    arm        = 1'b0;
    log_ev     = 1'b0;
    pop        = Rd_Ready && !fifo_empty;
    case (state_q)
      IDLE, DONE: begin
        // Stop wins over a simultaneous Start.
        if (Start && !Stop) begin
          state_d    = ARMED;
          arm        = 1'b1;
          ev_count_d = '0;
          ovf_d      = 1'b0;
        end
      end
      ARMED: begin
        log_ev = Det;
        if (Det) begin
          if (ev_count_q != {CNT_W{1'b1}}) ev_count_d = ev_count_q + CNT_W'(1);
          if (fifo_full && !pop) ovf_d = 1'b1;
        end
        if (Stop) begin
          state_d = DONE;
        end else if ((MAX_EV != 0) && Det && (ev_count_d == CNT_W'(MAX_EV))) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry payload: absolute stamp, or saturating gap since the last reference.
  always_comb begin
`ifdef SEQ_LOG_GAP_EN
    gap_d = gap_q;
    if (gap_q != {TS_W{1'b1}}) gap_d = gap_q + TS_W'(1);
    // Start and every event (logged or dropped) restart the reference.
    if (arm || log_ev) gap_d = TS_W'(1);
    wr_data = gap_q;
`else
    wr_data = ts_q;
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      ts_q       <= '0;
      ev_count_q <= '0;
      ovf_q      <= 1'b0;
`ifdef SEQ_LOG_GAP_EN
      gap_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      ev_count_q <= ev_count_d;
      ovf_q      <= ovf_d;
`ifdef SEQ_LOG_GAP_EN
      gap_q      <= gap_d;
`endif
    end
  end

  seq_det_ts_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk     (Clk),
    .Rst     (Rst),
    .Wr_En   (log_ev),
    .Wr_Data (wr_data),
    .Rd_En   (Rd_Ready),
    .Rd_Data (Rd_Data),
    .Full    (fifo_full),
    .Empty   (fifo_empty)
  );

endmodule
